// File: rtl/spc700_decadj_seq.sv
// spc700_decadj_seq: multi-cycle DAA/DAS sequencer (coarse 0x60 then fine 0x06 correction).
// Define SPC_DECADJ_FLAGS_EN to register N/Z alongside A_OUT; otherwise they are tied low.
module spc700_decadj_seq #(
    parameter int EXTRA_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic       op_das,
    input  logic [7:0] a_in,
    input  logic       c_in,
    input  logic       h_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] a_out,
    output logic       c_out,
    output logic       n_out,
    output logic       z_out
);
    typedef enum logic [2:0] {IDLE, LATCH, COARSE, FINE, PAD} state_t;
    localparam logic [1:0] PADS = EXTRA_WAIT > 3 ? 2'd3 : EXTRA_WAIT < 0 ? 2'd0 : 2'(EXTRA_WAIT);
    state_t state, state_n;
    logic [7:0] a_l, t, t_n;
    logic [1:0] cnt, cnt_n;
    logic c_l, h_l, das_l, c, c_n, accept, fin, coarse_adj, fine_adj;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else if (en) state <= state_n;
    end
    assign coarse_adj = das_l ? (!c || t > 8'h99) : (c || t > 8'h99);
    assign fine_adj = das_l ? (!h_l || t[3:0] > 4'd9) : (h_l || t[3:0] > 4'd9);
    always_comb begin
        state_n = state;
        t_n = t;
        c_n = c;
        cnt_n = cnt;
        accept = 1'b0;
        fin = 1'b0;
        case (state)
            IDLE: begin
                // a request coinciding with the DONE pulse waits one cycle
                accept = start && !done;
                state_n = accept ? LATCH : IDLE;
            end
            LATCH: begin
                t_n = a_l;
                c_n = c_l;
                state_n = COARSE;
            end
            COARSE: begin
                t_n = coarse_adj ? (das_l ? t - 8'h60 : t + 8'h60) : t;
                c_n = coarse_adj ? !das_l : c;
                state_n = FINE;
            end
            FINE: begin
                t_n = fine_adj ? (das_l ? t - 8'h06 : t + 8'h06) : t;
                cnt_n = 2'd0;
                fin = PADS == 2'd0;
                state_n = fin ? IDLE : PAD;
            end
            PAD: begin
                cnt_n = cnt + 2'd1;
                fin = cnt == PADS - 2'd1;
                state_n = fin ? IDLE : PAD;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_l <= 8'h00;
            c_l <= 1'b0;
            h_l <= 1'b0;
            das_l <= 1'b0;
            t <= 8'h00;
            c <= 1'b0;
            cnt <= 2'd0;
            busy <= 1'b0;
            done <= 1'b0;
            a_out <= 8'h00;
            c_out <= 1'b0;
        end else if (en) begin
            if (accept) begin
                a_l <= a_in;
                c_l <= c_in;
                h_l <= h_in;
                das_l <= op_das;
            end
            t <= t_n;
            c <= c_n;
            cnt <= cnt_n;
            done <= fin;
            busy <= accept ? 1'b1 : fin ? 1'b0 : busy;
            if (state == FINE) begin
                a_out <= t_n;
                c_out <= c;
            end
        end
    end
`ifdef SPC_DECADJ_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_out <= 1'b0;
            z_out <= 1'b0;
        end else if (en && state == FINE) begin
            n_out <= t_n[7];
            z_out <= t_n == 8'h00;
        end
    end
`else
    assign n_out = 1'b0;
    assign z_out = 1'b0;
`endif
endmodule

// File: tb/tb_spc700_decadj_seq.sv
// tb_spc700_decadj_seq: directed DAA/DAS vectors; a scoreboard queue is checked on every DONE pulse.
module tb_spc700_decadj_seq;
`ifdef SPC_DECADJ_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif
    typedef struct packed {
        logic [7:0] a;
        logic c;
        logic n;
        logic z;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, en = 1'b1, start = 1'b0, start2 = 1'b0;
    logic op_das = 1'b0, c_in = 1'b0, h_in = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic busy, done, c_out, n_out, z_out;
    logic [7:0] a_out;
    logic busy2, done2, c_out2, n_out2, z_out2;
    logic [7:0] a_out2;
    logic busy3, done3, c_out3, n_out3, z_out3;
    logic [7:0] a_out3;
    exp_t q[$];
    int npass = 0, ntot = 0;

    spc700_decadj_seq #(.EXTRA_WAIT(0)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .op_das(op_das), .a_in(a_in),
        .c_in(c_in), .h_in(h_in), .busy(busy), .done(done), .a_out(a_out),
        .c_out(c_out), .n_out(n_out), .z_out(z_out));
    spc700_decadj_seq #(.EXTRA_WAIT(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .start(start2), .op_das(op_das), .a_in(a_in),
        .c_in(c_in), .h_in(h_in), .busy(busy2), .done(done2), .a_out(a_out2),
        .c_out(c_out2), .n_out(n_out2), .z_out(z_out2));
    spc700_decadj_seq #(.EXTRA_WAIT(6)) dut3 (
        .clk(clk), .rst(rst), .en(en), .start(start2), .op_das(op_das), .a_in(a_in),
        .c_in(c_in), .h_in(h_in), .busy(busy3), .done(done3), .a_out(a_out3),
        .c_out(c_out3), .n_out(n_out3), .z_out(z_out3));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [7:0] a, input logic c);
        return '{a: a, c: c, n: FLAGS & a[7], z: FLAGS & (a == 8'h00)};
    endfunction

    // monitor: one pop per EN-qualified DONE cycle
    always @(negedge clk) begin
        if (!rst && en && done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("a_out", a_out, e.a);
                chk("c_out", c_out, e.c);
                chk("n_out", n_out, e.n);
                chk("z_out", z_out, e.z);
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", done, 1);
    endtask

    task automatic op(input logic das, input logic [7:0] a, input logic ci, input logic hi,
                      input logic [7:0] ea, input logic ec, input bit tog);
        int lat;
        logic got;
        op_das = das; a_in = a; c_in = ci; h_in = hi; start = 1'b1; en = 1'b1;
        q.push_back(mk(ea, ec));
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i < 60 && !got; i++) begin
            en = tog ? (i % 3 == 0) : 1'b1;
            @(posedge clk);
            if (en) lat++;
            #1;
            got = done;
        end
        chk("done_seen", got, 1);
        chk("latency_en_cycles", lat, 3);
        chk("busy_at_done", busy, 0);
        if (tog) begin
            en = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("done_held_en0", done, 1);
        end
        en = 1'b1;
        @(posedge clk); #1;
        chk("done_cleared", done, 0);
    endtask

    initial begin
        int n, l2, l3;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_a", a_out, 8'h00);
        chk("rst_c", c_out, 0);
        chk("rst_n", n_out, 0);
        chk("rst_z", z_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        op(1'b0, 8'h9A, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op(1'b0, 8'h15, 1'b0, 1'b1, 8'h1B, 1'b0, 1'b0);
        op(1'b0, 8'h09, 1'b1, 1'b0, 8'h69, 1'b1, 1'b0);
        op(1'b1, 8'h20, 1'b0, 1'b0, 8'hBA, 1'b0, 1'b0);
        op(1'b1, 8'h0F, 1'b1, 1'b1, 8'h09, 1'b1, 1'b0);
        op(1'b0, 8'h99, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
        op(1'b1, 8'h99, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        op(1'b0, 8'h45, 1'b0, 1'b0, 8'h45, 1'b0, 1'b1);
        // START held high: second accept only after the DONE cycle
        op_das = 1'b0; a_in = 8'h38; c_in = 1'b0; h_in = 1'b1; start = 1'b1;
        q.push_back(mk(8'h3E, 1'b0));
        q.push_back(mk(8'h3E, 1'b0));
        @(posedge clk); #1;
        wait_done(n);
        chk("held_latency", n, 3);
        @(posedge clk); #1;
        chk("no_accept_on_done", busy, 0);
        @(posedge clk); #1;
        chk("accept_after_done", busy, 1);
        start = 1'b0;
        wait_done(n);
        chk("held_latency2", n, 3);
        @(posedge clk); #1;
        // padded instances: EXTRA_WAIT=2 and a clamped EXTRA_WAIT=6
        op_das = 1'b1; a_in = 8'hFF; c_in = 1'b1; h_in = 1'b0; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        l2 = 0; l3 = 0;
        for (int i = 1; i < 30 && l3 == 0; i++) begin
            @(posedge clk); #1;
            if (done2 && l2 == 0) l2 = i;
            if (done3 && l3 == 0) l3 = i;
        end
        chk("wait2_latency", l2, 5);
        chk("wait_clamp_latency", l3, 6);
        chk("wait2_a", a_out2, 8'h99);
        chk("wait2_c", c_out2, 0);
        @(posedge clk); #1;
        // reset while in COARSE
        op_das = 1'b0; a_in = 8'h66; c_in = 1'b0; h_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_a", a_out, 8'h00);
        chk("abort_c", c_out, 0);
        chk("abort_done", done, 0);
        #1 rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk("no_done_after_abort", n, 0);
        op(1'b0, 8'h7B, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
